// File: rtl/pio_shift_out_pkg.sv
// Shared types and sizing helpers for the PIO-to-74HC595 serializer.
package pio_shift_out_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StLatch = 2'd2
  } state_e;

  localparam int unsigned DefaultWidth  = 8;
  localparam int unsigned DefaultClkDiv = 4;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pio_shift_out_divider.sv
// Phase generator: half_tick ends each CLK_DIV-cycle phase, phase is 0 (low) or 1 (high).
module pio_shift_out_divider
  import pio_shift_out_pkg::*;
#(
  parameter int unsigned CLK_DIV = DefaultClkDiv
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic half_tick,
  output logic phase
);

  localparam int unsigned CntW = cnt_width(CLK_DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_d, cnt_q;
  logic            phase_d, phase_q;

  always_comb begin
    half_tick = (cnt_q == CntMax);
    cnt_d     = half_tick ? '0 : cnt_q + 1'b1;
    phase_d   = half_tick ? ~phase_q : phase_q;
    if (clr) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;

endmodule

// File: rtl/pio_shift_out.sv
// Serializes the PIO output word MSB first into a 74HC595-style register, then latches it.
// Optional periodic refresh of the last word: define PIO_SHIFT_OUT_REFRESH_EN.
module pio_shift_out
  import pio_shift_out_pkg::*;
#(
  parameter int unsigned WIDTH          = DefaultWidth,
  parameter int unsigned CLK_DIV        = DefaultClkDiv,
  parameter int unsigned REFRESH_CYCLES = 65536
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pio_data,
  output logic             sr_clk,
  output logic             sr_data,
  output logic             sr_latch,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned BitW = cnt_width(WIDTH);

  state_e          state_d, state_q;
  logic [WIDTH-1:0] shreg_d, shreg_q;
  logic [WIDTH-1:0] last_sent_d, last_sent_q;
  logic [BitW-1:0]  bit_cnt_d, bit_cnt_q;
  logic             pending_d, pending_q;
  logic             done_d, done_q;
  logic             start, half_tick, phase, refresh_due;

  assign start = (state_q == StIdle) && ((pio_data != last_sent_q) || pending_q);

  // Held cleared while idle so every frame begins at the start of a low phase.
  pio_shift_out_divider #(
    .CLK_DIV (CLK_DIV)
  ) u_divider (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_q == StIdle),
    .half_tick (half_tick),
    .phase     (phase)
  );

`ifdef PIO_SHIFT_OUT_REFRESH_EN
  localparam int unsigned IdleW = cnt_width(REFRESH_CYCLES);
  localparam logic [IdleW-1:0] IdleMax = IdleW'(REFRESH_CYCLES - 1);

  logic [IdleW-1:0] idle_cnt_d, idle_cnt_q;

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (start) begin
      idle_cnt_d = '0;
    end else if ((state_q == StIdle) && (idle_cnt_q != IdleMax)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
  end

  assign refresh_due = (state_q == StIdle) && !start && (idle_cnt_q == IdleMax);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt_q <= '0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
    end
  end
`else
  logic unused_refresh;
  assign unused_refresh = (REFRESH_CYCLES == 0);
  assign refresh_due    = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    last_sent_d = last_sent_q;
    bit_cnt_d   = bit_cnt_q;
    pending_d   = pending_q | refresh_due;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shreg_d     = pio_data;
          last_sent_d = pio_data;
          pending_d   = 1'b0;
          bit_cnt_d   = BitW'(WIDTH - 1);
          state_d     = StShift;
        end
      end
      StShift: begin
        if (half_tick && phase) begin
          shreg_d = shreg_q << 1;
          if (bit_cnt_q == '0) begin
            state_d = StLatch;
          end else begin
            bit_cnt_d = bit_cnt_q - 1'b1;
          end
        end
      end
      StLatch: begin
        if (half_tick) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      last_sent_q <= '0;
      bit_cnt_q   <= '0;
      pending_q   <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      last_sent_q <= last_sent_d;
      bit_cnt_q   <= bit_cnt_d;
      pending_q   <= pending_d;
      done_q      <= done_d;
    end
  end

  assign busy       = (state_q != StIdle);
  assign sr_clk     = (state_q == StShift) && phase;
  assign sr_data    = (state_q == StShift) && shreg_q[WIDTH-1];
  assign sr_latch   = (state_q == StLatch);
  assign frame_done = done_q;

endmodule

// File: tb/tb_pio_shift_out.sv
// Directed bench for pio_shift_out with a 74HC595 receiver model; a second instance uses CLK_DIV=1.
module tb_pio_shift_out;

  localparam int unsigned R = 100;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pio_data = 8'h00;
  logic       sr_clk, sr_data, sr_latch, busy, frame_done;

  logic       rst_f = 1'b1;
  logic [7:0] pio_f = 8'h00;
  logic       sr_clk_f, sr_data_f, sr_latch_f, busy_f, frame_done_f;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pio_shift_out #(
    .WIDTH          (8),
    .CLK_DIV        (4),
    .REFRESH_CYCLES (R)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pio_data   (pio_data),
    .sr_clk     (sr_clk),
    .sr_data    (sr_data),
    .sr_latch   (sr_latch),
    .busy       (busy),
    .frame_done (frame_done)
  );

  pio_shift_out #(
    .WIDTH          (8),
    .CLK_DIV        (1),
    .REFRESH_CYCLES (R)
  ) dut_fast (
    .clk        (clk),
    .reset      (rst_f),
    .pio_data   (pio_f),
    .sr_clk     (sr_clk_f),
    .sr_data    (sr_data_f),
    .sr_latch   (sr_latch_f),
    .busy       (busy_f),
    .frame_done (frame_done_f)
  );

  // External shift/storage register models and free-running event counters.
  logic [7:0] ext_sr = 8'hFF, ext_q = 8'hFF;
  logic [7:0] f_sr = 8'hFF, f_q = 8'hFF;
  int clk_rises = 0, lat_cycles = 0, done_cnt = 0;
  int f_clk_rises = 0, f_lat_cycles = 0;

  always @(posedge sr_clk) begin
    ext_sr    <= {ext_sr[6:0], sr_data};
    clk_rises <= clk_rises + 1;
  end
  always @(posedge sr_latch) ext_q <= ext_sr;
  always @(posedge sr_clk_f) begin
    f_sr        <= {f_sr[6:0], sr_data_f};
    f_clk_rises <= f_clk_rises + 1;
  end
  always @(posedge sr_latch_f) f_q <= f_sr;
  always @(posedge clk) begin
    if (sr_latch)   lat_cycles   <= lat_cycles + 1;
    if (frame_done) done_cnt     <= done_cnt + 1;
    if (sr_latch_f) f_lat_cycles <= f_lat_cycles + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs from a negedge until the first idle negedge after a frame; counts busy negedges.
  task automatic wait_frame(output int blen, output logic ok);
    int n;
    n    = 0;
    blen = 0;
    ok   = 1'b0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      while (busy && blen < 300) begin
        blen++;
        @(negedge clk);
      end
      ok = !busy;
    end
  endtask

  int   blen, c0, l0, d0, n;
  logic ok;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_sr_clk", sr_clk, 1'b0);
    check("rst_sr_data", sr_data, 1'b0);
    check("rst_sr_latch", sr_latch, 1'b0);
    check("rst_frame_done", frame_done, 1'b0);

    // Forced frame of zeros after reset release
    c0 = clk_rises;
    l0 = lat_cycles;
    reset = 1'b0;
    wait_frame(blen, ok);
    check("zero_ok", ok, 1'b1);
    check("zero_busy_len", blen, 68);
    check("zero_done", frame_done, 1'b1);
    check("zero_word", ext_q, 8'h00);
    check("zero_bits", clk_rises - c0, 8);
    check("zero_latch_len", lat_cycles - l0, 4);
    @(negedge clk);
    check("zero_done_once", frame_done, 1'b0);

    // 0x00 -> 0xA5: one-cycle start latency, MSB first
    c0 = clk_rises;
    pio_data = 8'hA5;
    @(negedge clk);
    check("a5_busy_start", busy, 1'b1);
    check("a5_first_bit", sr_data, 1'b1);
    check("a5_clk_low", sr_clk, 1'b0);
    wait_frame(blen, ok);
    check("a5_ok", ok, 1'b1);
    check("a5_busy_len", blen, 68);
    check("a5_word", ext_q, 8'hA5);
    check("a5_bits", clk_rises - c0, 8);
    check("a5_done", frame_done, 1'b1);

    // Changes during a frame: 0x3C is overwritten by 0xC3 before sampling
    l0 = lat_cycles;
    pio_data = 8'h11;
    repeat (20) @(negedge clk);
    pio_data = 8'h3C;
    repeat (20) @(negedge clk);
    pio_data = 8'hC3;
    wait_frame(blen, ok);
    check("mid_ok", ok, 1'b1);
    check("mid_word", ext_q, 8'h11);
    check("mid_done", frame_done, 1'b1);
    // Back-to-back: next frame starts at the end of the frame_done cycle
    @(negedge clk);
    check("b2b_busy", busy, 1'b1);
    repeat (10) @(negedge clk);
    pio_data = 8'h77;
    repeat (10) @(negedge clk);
    pio_data = 8'hC3;
    wait_frame(blen, ok);
    check("c3_ok", ok, 1'b1);
    check("c3_word", ext_q, 8'hC3);
    check("c3_latch_total", lat_cycles - l0, 8);
    @(negedge clk);

    // Constant data: refresh frames only when the feature is built in
    d0 = done_cnt;
    repeat (3 * (R + 69) + 10) @(negedge clk);
`ifdef PIO_SHIFT_OUT_REFRESH_EN
    check("refresh_frames", done_cnt - d0, 3);
`else
    check("refresh_frames", done_cnt - d0, 0);
`endif
    check("refresh_word", ext_q, 8'hC3);

    // Reset in the middle of SHIFT, then a full 0x81 frame
    pio_data = 8'h81;
    @(negedge clk);
    @(negedge clk);
    check("r81_busy", busy, 1'b1);
    check("r81_msb", sr_data, 1'b1);
    reset = 1'b1;
    #1;
    check("r81_rst_busy", busy, 1'b0);
    check("r81_rst_data", sr_data, 1'b0);
    check("r81_rst_clk", sr_clk, 1'b0);
    check("r81_rst_latch", sr_latch, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    wait_frame(blen, ok);
    check("r81_ok", ok, 1'b1);
    check("r81_busy_len", blen, 68);
    check("r81_word", ext_q, 8'h81);

    // CLK_DIV = 1 instance
    check("fast_rst_busy", busy_f, 1'b0);
    check("fast_rst_clk", sr_clk_f, 1'b0);
    pio_f = 8'h96;
    c0    = f_clk_rises;
    l0    = f_lat_cycles;
    rst_f = 1'b0;
    n     = 0;
    while (!busy_f && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("fast_started", busy_f, 1'b1);
    blen = 0;
    while (busy_f && blen < 100) begin
      blen++;
      @(negedge clk);
    end
    check("fast_busy_len", blen, 17);
    check("fast_done", frame_done_f, 1'b1);
    check("fast_word", f_q, 8'h96);
    check("fast_bits", f_clk_rises - c0, 8);
    check("fast_latch_len", f_lat_cycles - l0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
